// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_FWD_EN (operand forwarding vs. RAW stalling).
package pipe_pkg;

  localparam int N        = 32;
  localparam int M        = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // M-stage result is younger than W-stage result, so it wins.
  function automatic fwd_sel_t fwd_sel(input logic         regw_M,
                                       input logic [M-1:0] rd_M,
                                       input logic         regw_W,
                                       input logic [M-1:0] rd_W,
                                       input logic [M-1:0] rs);
    if (regw_M && (rd_M == rs))      return FWD_M;
    else if (regw_W && (rd_W == rs)) return FWD_W;
    else                             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives stage info), slave: hazard_ctrl.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic [M-1:0] rs1_D, rs2_D, rs1_E, rs2_E;
  logic [M-1:0] rd_E, rd_M, rd_W;
  logic         regw_E, regw_M, regw_W;
  logic         regmem_E;
  logic         pcload_D, pcload_E, pcload_M, pcload_W;
  logic         brtaken_E;
  logic         memreq_M, mem_rdy;
  logic         stall_F, stall_D, stall_E, stall_M;
  logic         flush_D, flush_E, flush_M, flush_W;
  logic [1:0]   fwd_a_E, fwd_b_E;
  logic         mem_timeout;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           regw_E, regw_M, regw_W, regmem_E,
           pcload_D, pcload_E, pcload_M, pcload_W, brtaken_E,
           memreq_M, mem_rdy,
    input  stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W,
           fwd_a_E, fwd_b_E, mem_timeout
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           regw_E, regw_M, regw_W, regmem_E,
           pcload_D, pcload_E, pcload_M, pcload_W, brtaken_E,
           memreq_M, mem_rdy,
    output stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W,
           fwd_a_E, fwd_b_E, mem_timeout
  );

endinterface

// File: rtl/hazard_ctrl_mem_wait.sv
// Data-memory wait sequencer: tracks outstanding access, counts wait cycles, flags timeout.
//  state    | meaning
//  RUN      | no access outstanding beyond the current cycle
//  MEM_WAIT | access issued earlier, waiting for mem_rdy
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = pipe_pkg::MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic memreq_M,
  input  logic mem_rdy,
  output logic memstall,
  output logic mem_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  hz_state_t       state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            timeout_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (memreq_M && !mem_rdy) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_rdy) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt != CW'(MAX_WAIT)) begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    memstall    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      RUN:      memstall = memreq_M && !mem_rdy;
      MEM_WAIT: begin
        memstall    = !mem_rdy;
        timeout_set = !mem_rdy && (wait_cnt == CW'(MAX_WAIT));
      end
      default:  memstall = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the F/D/E/M/W pipeline.
// Build option: define HAZARD_FWD_EN for EX forwarding; otherwise RAW hazards stall.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = pipe_pkg::MAX_WAIT
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  logic memstall;
  logic timeout;
  logic pcpend;
  logic datastall;

  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .memreq_M   (hz.memreq_M),
    .mem_rdy    (hz.mem_rdy),
    .memstall   (memstall),
    .mem_timeout(timeout)
  );

  assign hz.mem_timeout = timeout;
  assign pcpend         = hz.pcload_D | hz.pcload_E | hz.pcload_M;

`ifdef HAZARD_FWD_EN
  assign datastall = hz.regmem_E & hz.regw_E &
                     ((hz.rd_E == hz.rs1_D) | (hz.rd_E == hz.rs2_D));

  always_comb begin
    hz.fwd_a_E = FWD_RF;
    hz.fwd_b_E = FWD_RF;
    if (!rst) begin
      hz.fwd_a_E = fwd_sel(hz.regw_M, hz.rd_M, hz.regw_W, hz.rd_W, hz.rs1_E);
      hz.fwd_b_E = fwd_sel(hz.regw_M, hz.rd_M, hz.regw_W, hz.rd_W, hz.rs2_E);
    end
  end
`else
  // W-stage writers are safe: the regfile writes before it is read.
  logic unused_fwd;
  assign datastall = (hz.regw_E & ((hz.rd_E == hz.rs1_D) | (hz.rd_E == hz.rs2_D))) |
                     (hz.regw_M & ((hz.rd_M == hz.rs1_D) | (hz.rd_M == hz.rs2_D)));
  assign hz.fwd_a_E = FWD_RF;
  assign hz.fwd_b_E = FWD_RF;
  assign unused_fwd = ^{hz.regmem_E, hz.rs1_E, hz.rs2_E, hz.rd_W, hz.regw_W};
`endif

  // A pending memory access freezes everything; a taken branch seen meanwhile is
  // re-evaluated once the stall lifts because brtaken_E is held in place.
  always_comb begin
    hz.stall_F = 1'b0;
    hz.stall_D = 1'b0;
    hz.stall_E = 1'b0;
    hz.stall_M = 1'b0;
    hz.flush_D = 1'b0;
    hz.flush_E = 1'b0;
    hz.flush_M = 1'b0;
    hz.flush_W = 1'b0;
    if (rst) begin
      hz.flush_D = 1'b1;
      hz.flush_E = 1'b1;
      hz.flush_M = 1'b1;
      hz.flush_W = 1'b1;
    end else if (memstall) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.stall_E = 1'b1;
      hz.stall_M = 1'b1;
      hz.flush_W = 1'b1;
    end else begin
      hz.stall_F = datastall | pcpend;
      hz.stall_D = datastall & ~hz.brtaken_E;
      hz.flush_D = pcpend | hz.pcload_W | hz.brtaken_E;
      hz.flush_E = datastall | hz.brtaken_E;
    end
  end

endmodule
